clock_time_set_ctrl: RTL and testbench
======================================

Name: clock_time_set_ctrl

Overview:
Time-setting controller for the 24-hour BCD clock counter (HH:MM:SS). It conditions three user keys and runs a mode FSM (RUN / SET_HR / SET_MI / SET_SE) that freezes the counter and edits a captured copy of the time. On exit it issues a one-cycle parallel load back into the counter. It also drives a digit blink mask for the display scanner. It sits between the key pins and the clock counter and display mux at top level.

Parameters:
DEB_CNT, 1_000_000, cycles a key level must be stable before it is accepted (20 ms at 50 MHz).
BLINK_CNT, 25_000_000, cycles per blink phase (0.5 s at 50 MHz).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
key_mode  in  1  mode key, raw pin, active-low
key_inc  in  1  increment key, raw pin, active-low
key_dec  in  1  decrement key, raw pin, active-low
cur_hr_t  in  2  counter hours tens (0-2)
cur_hr_u  in  4  counter hours units (0-9)
cur_mi_t  in  3  counter minutes tens (0-5)
cur_mi_u  in  4  counter minutes units
cur_se_t  in  3  counter seconds tens (0-5)
cur_se_u  in  4  counter seconds units
run_en  out  1  1 = counter may advance; top level gates its tick with this
load  out  1  one-cycle pulse; counter loads ld_* when 1
ld_hr_t  out  2  edit value, hours tens
ld_hr_u  out  4  edit value, hours units
ld_mi_t  out  3  edit value, minutes tens
ld_mi_u  out  4  edit value, minutes units
ld_se_t  out  3  edit value, seconds tens
ld_se_u  out  4  edit value, seconds units
mode  out  2  0 RUN, 1 SET_HR, 2 SET_MI, 3 SET_SE
blink_mask  out  6  1 = blank digit; bits [5:0] = hr_t, hr_u, mi_t, mi_u, se_t, se_u

Behaviour:
- All state is synchronous to clk. When rst_n=0 at a clk edge, the following reset values apply:
  - mode=0, run_en=1, load=0, all ld_*=0, blink_mask=0.
  - Synchronizers and debounced levels are set to 1 (idle); debounce and blink counters are set to 0.
- Key conditioning, per key:
  - 2-FF synchronizer.
  - Debounce counter counts while the synced level differs from the debounced level and clears when they match.
  - At DEB_CNT-1 the debounced level takes the synced level.
  - A debounced 1->0 transition produces a one-cycle internal event.
  - Any pulse shorter than DEB_CNT cycles produces no event.
  - Pin-to-event latency is DEB_CNT+3 cycles.
  - Release produces no event.
- FSM on mode events:
  - RUN -> SET_HR. In the event cycle, cur_* are captured into the edit registers (ld_*). run_en goes 0 on the next cycle.
  - SET_HR -> SET_MI -> SET_SE.
  - SET_SE -> RUN. load=1 for exactly the first RUN cycle, with ld_* stable. run_en=1 in that same cycle.
- Event priority:
  - Mode event in the same cycle as inc/dec: mode wins, and inc/dec is dropped.
  - inc and dec in the same cycle: both are ignored.
  - inc/dec in RUN: ignored.
- Editing applies to the field selected by mode only. No carry or borrow into other fields.
- Edit arithmetic is BCD and results are always valid BCD:
  - Hours: inc 23 -> 00, otherwise +1 (09 -> 10, 19 -> 20). dec 00 -> 23, otherwise -1 (10 -> 09, 20 -> 19).
  - Minutes and seconds: inc 59 -> 00, dec 00 -> 59.
- ld_* always reflect the edit registers. Between edits they hold their last value; they do not follow the counter in RUN.
- Blink:
  - blink counter counts 0..BLINK_CNT-1 and toggles phase on wrap.
  - Any mode, inc or dec event restarts the counter with phase=0.
  - blink_mask = selected field pair when mode!=0 and phase=1; otherwise 0. SET_HR=6'b110000, SET_MI=6'b001100, SET_SE=6'b000011.
- Reset mid-edit abandons the edit: no load pulse, returns to RUN.
- Captured values are assumed legal. Out-of-range captured hours (e.g. 24) are incremented to 00 on inc.

Test Plan:
- Bench settings: DEB_CNT=4, BLINK_CNT=8.
- Reset -> mode=0, run_en=1, load=0, ld_*=0, blink_mask=0. Hold key_inc low in RUN -> no change.
- cur=13:45:27, press mode -> mode=1, ld=13:45:27, run_en=0. 11 inc presses -> ld hours 00 (via 19->20, 23->00). 1 dec press -> 23.
- In SET_MI with ld minutes=59, inc -> 00 and hours unchanged. dec -> 59. Simultaneous inc+dec -> unchanged.
- Advance to SET_SE, set seconds 00 via dec from 01. Mode press -> load=1 for exactly one cycle with ld=23:59:00, mode=0, run_en=1.
- Key_mode low for 2 cycles only -> no event. Mode and inc events in the same cycle -> mode advances, field unchanged.
- In SET_HR, no key activity -> blink_mask alternates 6'b000000 / 6'b110000 every 8 cycles. An inc event restarts blinking with mask 0. Assert rst_n=0 in SET_MI -> mode=0, run_en=1, no load pulse.

Source files
------------

// File: rtl/clock_time_set_ctrl.sv
// Time-setting controller for the HH:MM:SS BCD counter: key conditioning,
// RUN/SET_HR/SET_MI/SET_SE mode FSM, BCD field editing, load pulse and blink mask.

module clock_time_set_ctrl_key #(
  parameter int DEB_CNT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic ev
);
  localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          deb_q, deb_d, deb_dly_q, deb_dly_d, ev_q, ev_d;
  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    cnt_d     = '0;
    deb_dly_d = deb_q;
    ev_d      = deb_dly_q & ~deb_q;
    // the level must disagree for DEB_CNT consecutive cycles before it is taken
    if (sync2_q != deb_q) begin
      if (cnt_q == DW'(DEB_CNT - 1)) deb_d = sync2_q;
      else                           cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_dly_q <= 1'b1;
      cnt_q     <= '0;
      ev_q      <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_dly_d;
      cnt_q     <= cnt_d;
      ev_q      <= ev_d;
    end
  end

  assign ev = ev_q;
endmodule

module clock_time_set_ctrl #(
  parameter int DEB_CNT   = 1_000_000,
  parameter int BLINK_CNT = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [1:0] cur_hr_t,
  input  logic [3:0] cur_hr_u,
  input  logic [2:0] cur_mi_t,
  input  logic [3:0] cur_mi_u,
  input  logic [2:0] cur_se_t,
  input  logic [3:0] cur_se_u,
  output logic       run_en,
  output logic       load,
  output logic [1:0] ld_hr_t,
  output logic [3:0] ld_hr_u,
  output logic [2:0] ld_mi_t,
  output logic [3:0] ld_mi_u,
  output logic [2:0] ld_se_t,
  output logic [3:0] ld_se_u,
  output logic [1:0] mode,
  output logic [5:0] blink_mask
);
  localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MI = 2'd2, SET_SE = 2'd3} mode_e;

  logic [2:0] keys_n, key_ev;
  assign keys_n = {key_dec, key_inc, key_mode};

  for (genvar k = 0; k < 3; k++) begin : g_key
    clock_time_set_ctrl_key #(.DEB_CNT(DEB_CNT)) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (keys_n[k]),
      .ev    (key_ev[k])
    );
  end

  logic ev_mode, ev_inc, ev_dec;
  assign ev_mode = key_ev[0];
  assign ev_inc  = key_ev[1];
  assign ev_dec  = key_ev[2];

  mode_e         mode_q, mode_d;
  logic          load_q, load_d;
  logic [1:0]    hr_t_q, hr_t_d;
  logic [3:0]    hr_u_q, hr_u_d;
  logic [2:0]    mi_t_q, mi_t_d, se_t_q, se_t_d;
  logic [3:0]    mi_u_q, mi_u_d, se_u_q, se_u_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic          do_inc, do_dec, do_edit;

  // 23 wraps to 00; anything past 23 is also folded to 00 on increment
  function automatic logic [5:0] hr_step(input logic [1:0] t, input logic [3:0] u, input logic up);
    logic [5:0] r;
    if (up) begin
      if ((t == 2'd2 && u >= 4'd3) || t == 2'd3) r = 6'd0;
      else if (u >= 4'd9)                        r = {t + 2'd1, 4'd0};
      else                                       r = {t, u + 4'd1};
    end else begin
      if (t == 2'd0 && u == 4'd0) r = {2'd2, 4'd3};
      else if (u == 4'd0)         r = {t - 2'd1, 4'd9};
      else                        r = {t, u - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] ms_step(input logic [2:0] t, input logic [3:0] u, input logic up);
    logic [6:0] r;
    if (up) begin
      if (u >= 4'd9) r = (t >= 3'd5) ? 7'd0 : {t + 3'd1, 4'd0};
      else           r = {t, u + 4'd1};
    end else begin
      if (u == 4'd0) r = (t == 3'd0) ? {3'd5, 4'd9} : {t - 3'd1, 4'd9};
      else           r = {t, u - 4'd1};
    end
    return r;
  endfunction

  // mode wins over edits; inc together with dec cancels out
  assign do_edit = (mode_q != RUN) && !ev_mode && (ev_inc ^ ev_dec);
  assign do_inc  = do_edit && ev_inc;
  assign do_dec  = do_edit && ev_dec;

  always_comb begin
    mode_d = mode_q;
    load_d = 1'b0;
    hr_t_d = hr_t_q;
    hr_u_d = hr_u_q;
    mi_t_d = mi_t_q;
    mi_u_d = mi_u_q;
    se_t_d = se_t_q;
    se_u_d = se_u_q;
    if (ev_mode) begin
      case (mode_q)
        RUN: begin
          mode_d = SET_HR;
          hr_t_d = cur_hr_t;
          hr_u_d = cur_hr_u;
          mi_t_d = cur_mi_t;
          mi_u_d = cur_mi_u;
          se_t_d = cur_se_t;
          se_u_d = cur_se_u;
        end
        SET_HR:  mode_d = SET_MI;
        SET_MI:  mode_d = SET_SE;
        default: begin
          mode_d = RUN;
          load_d = 1'b1;
        end
      endcase
    end else if (do_inc || do_dec) begin
      case (mode_q)
        SET_HR:  {hr_t_d, hr_u_d} = hr_step(hr_t_q, hr_u_q, do_inc);
        SET_MI:  {mi_t_d, mi_u_d} = ms_step(mi_t_q, mi_u_q, do_inc);
        default: {se_t_d, se_u_d} = ms_step(se_t_q, se_u_q, do_inc);
      endcase
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (|key_ev) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CNT - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= RUN;
      load_q      <= 1'b0;
      hr_t_q      <= '0;
      hr_u_q      <= '0;
      mi_t_q      <= '0;
      mi_u_q      <= '0;
      se_t_q      <= '0;
      se_u_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      load_q      <= load_d;
      hr_t_q      <= hr_t_d;
      hr_u_q      <= hr_u_d;
      mi_t_q      <= mi_t_d;
      mi_u_q      <= mi_u_d;
      se_t_q      <= se_t_d;
      se_u_q      <= se_u_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    blink_mask = 6'b000000;
    if (phase_q) begin
      case (mode_q)
        SET_HR:  blink_mask = 6'b110000;
        SET_MI:  blink_mask = 6'b001100;
        SET_SE:  blink_mask = 6'b000011;
        default: blink_mask = 6'b000000;
      endcase
    end
  end

  assign run_en  = (mode_q == RUN);
  assign load    = load_q;
  assign mode    = mode_q;
  assign ld_hr_t = hr_t_q;
  assign ld_hr_u = hr_u_q;
  assign ld_mi_t = mi_t_q;
  assign ld_mi_u = mi_u_q;
  assign ld_se_t = se_t_q;
  assign ld_se_u = se_u_q;
endmodule

// File: tb/tb_clock_time_set_ctrl.sv
// Directed + randomized bench for clock_time_set_ctrl; fields are modelled as
// plain integers (hours mod 24, minutes/seconds mod 60) and a mode counter.

module tb_clock_time_set_ctrl;
  localparam int DEB  = 4;
  localparam int BLNK = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode = 1'b1, key_inc = 1'b1, key_dec = 1'b1;
  logic [1:0] cur_hr_t = '0;
  logic [3:0] cur_hr_u = '0;
  logic [2:0] cur_mi_t = '0;
  logic [3:0] cur_mi_u = '0;
  logic [2:0] cur_se_t = '0;
  logic [3:0] cur_se_u = '0;
  logic       run_en, load;
  logic [1:0] ld_hr_t;
  logic [3:0] ld_hr_u;
  logic [2:0] ld_mi_t;
  logic [3:0] ld_mi_u;
  logic [2:0] ld_se_t;
  logic [3:0] ld_se_u;
  logic [1:0] mode;
  logic [5:0] blink_mask;

  clock_time_set_ctrl #(.DEB_CNT(DEB), .BLINK_CNT(BLNK)) dut (
    .clk(clk), .rst_n(rst_n), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .cur_hr_t(cur_hr_t), .cur_hr_u(cur_hr_u), .cur_mi_t(cur_mi_t), .cur_mi_u(cur_mi_u),
    .cur_se_t(cur_se_t), .cur_se_u(cur_se_u), .run_en(run_en), .load(load),
    .ld_hr_t(ld_hr_t), .ld_hr_u(ld_hr_u), .ld_mi_t(ld_mi_t), .ld_mi_u(ld_mi_u),
    .ld_se_t(ld_se_t), .ld_se_u(ld_se_u), .mode(mode), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int mm = 0, h = 0, m = 0, s = 0;
  int cur_h = 0, cur_m = 0, cur_s = 0;
  int load_cnt = 0, load_h = 0, load_m = 0, load_s = 0;
  logic load_run = 1'b0;

  function automatic int hr_v();  return int'(ld_hr_t) * 10 + int'(ld_hr_u); endfunction
  function automatic int mi_v();  return int'(ld_mi_t) * 10 + int'(ld_mi_u); endfunction
  function automatic int se_v();  return int'(ld_se_t) * 10 + int'(ld_se_u); endfunction

  always @(negedge clk) begin
    if (load === 1'b1) begin
      load_cnt = load_cnt + 1;
      load_h   = hr_v();
      load_m   = mi_v();
      load_s   = se_v();
      load_run = run_en;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_mode"}, int'(mode), mm);
    chk({tag, "_run_en"}, int'(run_en), (mm == 0) ? 1 : 0);
    chk({tag, "_hr"}, hr_v(), h);
    chk({tag, "_mi"}, mi_v(), m);
    chk({tag, "_se"}, se_v(), s);
  endtask

  task automatic set_cur(input int hh, input int mi, input int ss);
    cur_h = hh; cur_m = mi; cur_s = ss;
    cur_hr_t = 2'(hh / 10); cur_hr_u = 4'(hh % 10);
    cur_mi_t = 3'(mi / 10); cur_mi_u = 4'(mi % 10);
    cur_se_t = 3'(ss / 10); cur_se_u = 4'(ss % 10);
  endtask

  // hold keys well past the debounce window, then release and let it settle
  task automatic press(input logic pm, input logic pi, input logic pd);
    @(negedge clk);
    key_mode = ~pm; key_inc = ~pi; key_dec = ~pd;
    repeat (DEB + 4) @(negedge clk);
    key_mode = 1'b1; key_inc = 1'b1; key_dec = 1'b1;
    repeat (DEB + 6) @(negedge clk);
  endtask

  task automatic model_edit(input bit up);
    case (mm)
      1: h = up ? (h + 1) % 24 : (h + 23) % 24;
      2: m = up ? (m + 1) % 60 : (m + 59) % 60;
      3: s = up ? (s + 1) % 60 : (s + 59) % 60;
      default: ;
    endcase
  endtask

  // kind: 0 inc, 1 dec, 2 both at once
  task automatic do_op(input int kind, input string tag);
    press(1'b0, kind != 1, kind != 0);
    if (mm != 0 && kind != 2) model_edit(kind == 0);
    chk_state(tag);
  endtask

  task automatic do_mode(input string tag);
    press(1'b1, 1'b0, 1'b0);
    if (mm == 0) begin h = cur_h; m = cur_m; s = cur_s; end
    mm = (mm + 1) % 4;
    chk_state(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int lc0, prev, seen;
    set_cur(13, 45, 27);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_load", int'(load), 0);
    chk("rst_mask", int'(blink_mask), 0);
    chk_state("rst");

    do_op(0, "run_inc_ignored");
    chk("run_no_load", load_cnt, 0);

    do_mode("enter_hr");
    for (int i = 0; i < 11; i++) do_op(0, "hr_inc");
    chk("hr_wrap_00", hr_v(), 0);
    do_op(1, "hr_dec");
    chk("hr_dec_23", hr_v(), 23);
    for (int i = 0; i < 8; i++) do_op(int'($urandom_range(0, 2)), "hr_rand");
    for (int i = 0; i < 24 && h != 23; i++) do_op(0, "hr_steer");

    do_mode("enter_mi");
    for (int i = 0; i < 60 && m != 59; i++) do_op(0, "mi_steer");
    do_op(0, "mi_inc_wrap");
    chk("mi_wrap_00", mi_v(), 0);
    chk("mi_wrap_hr_kept", hr_v(), 23);
    do_op(1, "mi_dec_wrap");
    chk("mi_dec_59", mi_v(), 59);
    do_op(2, "mi_inc_dec");
    for (int i = 0; i < 8; i++) do_op(int'($urandom_range(0, 2)), "mi_rand");
    for (int i = 0; i < 60 && m != 59; i++) do_op(0, "mi_steer2");

    // mode and inc together: mode advances, no field moves
    press(1'b1, 1'b1, 1'b0);
    mm = 3;
    chk_state("mode_plus_inc");

    for (int i = 0; i < 8; i++) do_op(int'($urandom_range(0, 2)), "se_rand");
    for (int i = 0; i < 60 && s != 1; i++) do_op(0, "se_steer");
    do_op(1, "se_dec_00");
    chk("se_00", se_v(), 0);

    lc0 = load_cnt;
    do_mode("exit_run");
    chk("load_pulses", load_cnt - lc0, 1);
    chk("load_hr", load_h, 23);
    chk("load_mi", load_m, 59);
    chk("load_se", load_s, 0);
    chk("load_run_en", int'(load_run), 1);
    chk("load_low_after", int'(load), 0);

    @(negedge clk);
    key_mode = 1'b0;
    repeat (2) @(negedge clk);
    key_mode = 1'b1;
    repeat (20) @(negedge clk);
    chk_state("short_pulse");
    do_op(0, "run_inc_hold");
    chk("no_extra_load", load_cnt - lc0, 1);

    set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
    do_mode("enter_hr2");

    // inc event restarts blink at phase 0, then alternates every BLNK cycles
    prev = hr_v();
    seen = 0;
    @(negedge clk);
    key_inc = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hr_v() != prev) begin seen = 1; break; end
    end
    key_inc = 1'b1;
    chk("blink_ev_seen", seen, 1);
    model_edit(1'b1);
    chk("blink_hr", hr_v(), h);
    for (int k = 0; k < 3 * BLNK; k++) begin
      chk("blink_mask", int'(blink_mask), ((k / BLNK) % 2 == 1) ? 6'b110000 : 0);
      @(negedge clk);
    end

    do_mode("enter_mi2");
    lc0 = load_cnt;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mm = 0; h = 0; m = 0; s = 0;
    chk_state("mid_edit_rst");
    chk("mid_rst_mask", int'(blink_mask), 0);
    repeat (6) @(negedge clk);
    chk("mid_rst_no_load", load_cnt - lc0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
